// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit in the execute stage.
// Multiplies by shift-add and divides by restoring division, one bit per cycle.
// Its result, destination index and one-cycle strobe drive the regfile write port.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op, op_w     request strobe, funct3 code, 32-bit (W) variant
//   rs1_data, rs2_data  source operands, sampled at the accepting edge
//   rd_in               destination register index
//   kill                pipeline flush; abandons the in-flight operation
//   busy                operation in flight; start is ignored while high
//   done                one-cycle completion pulse
//   result, rd_out      registered result and destination index

module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            op_w,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    logic [6:0]  cnt;
    logic [2:0]  op_q;
    logic        w_q;
    logic        fast_q;
    logic        neg_q;
    logic        neg_r;
    logic [4:0]  rd_q;
    logic [63:0] hi;
    logic [63:0] lo;
    logic [63:0] opa;
    logic [63:0] opb;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Request decode, evaluated on the raw inputs at the accepting edge.
    logic        is_div;
    logic        s1;
    logic        s2;
    logic [63:0] a_sx;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] a_mag;
    logic [63:0] b_mag;
    logic        div_zero;
    logic        div_ovf;
    logic        min_neg;
    logic [63:0] fast_val;

    always_comb begin
        is_div = op[2];
        s1 = (op == 3'd1) || (op == 3'd2)
          || (op == 3'd4) || (op == 3'd6);
        s2 = (op == 3'd1) || (op == 3'd4)
          || (op == 3'd6);
        // a_sx is the dividend as a W result sees it,
        // sign-extended regardless of signedness.
        a_sx = op_w ? sext32(rs1_data[31:0]) : rs1_data;
        a_ext = op_w
              ? {{32{s1 & rs1_data[31]}}, rs1_data[31:0]}
              : rs1_data;
        b_ext = op_w
              ? {{32{s2 & rs2_data[31]}}, rs2_data[31:0]}
              : rs2_data;
        a_neg = s1 & a_ext[63];
        b_neg = s2 & b_ext[63];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
        min_neg = op_w ? (rs1_data[31:0] == 32'h8000_0000)
                       : (rs1_data == {1'b1, 63'd0});
        div_zero = is_div && (b_ext == '0);
        div_ovf = is_div && !op[0] && min_neg
               && (b_ext == '1);
        if (op[1]) begin
            fast_val = div_zero ? a_sx : '0;
        end else begin
            fast_val = div_zero ? '1 : a_sx;
        end
    end

    // One iteration. Multiply keeps a 128-bit accumulator {hi, lo}
    // shifted right each cycle; divide keeps the partial remainder
    // in hi and shifts the dividend out of lo while quotient bits
    // shift in.
    logic [64:0] sum;
    logic [64:0] rem_sh;
    logic [64:0] diff;
    logic        ge;
    logic [63:0] hi_n;
    logic [63:0] lo_n;
    logic [63:0] opb_n;

    always_comb begin
        sum = {1'b0, hi} + (opb[0] ? {1'b0, opa} : 65'd0);
        rem_sh = {hi, lo[63]};
        diff = rem_sh - {1'b0, opb};
        ge = ~diff[64];
        if (op_q[2]) begin
            hi_n = ge ? diff[63:0] : rem_sh[63:0];
            lo_n = {lo[62:0], ge};
            opb_n = opb;
        end else begin
            hi_n = sum[64:1];
            lo_n = {sum[0], lo[63:1]};
            opb_n = {1'b0, opb[63:1]};
        end
    end

    // Sign correction and result select on the final iteration.
    logic [127:0] prod;
    logic [127:0] prod_c;
    logic [63:0]  q_c;
    logic [63:0]  r_c;
    logic [63:0]  res_n;

    always_comb begin
        prod = {hi_n, lo_n};
        prod_c = neg_q ? -prod : prod;
        q_c = neg_q ? -lo_n : lo_n;
        r_c = neg_r ? -hi_n : hi_n;
        res_n = '0;
        if (fast_q) begin
            res_n = lo;
        end else begin
            case (op_q)
                // 32 iterations leave the W product at [63:32] of
                // the accumulator.
                3'd0:
                    res_n = w_q ? sext32(lo_n[63:32])
                                : prod_c[63:0];
                3'd1, 3'd2, 3'd3:
                    res_n = prod_c[127:64];
                3'd4, 3'd5:
                    res_n = w_q ? sext32(q_c[31:0]) : q_c;
                default:
                    res_n = w_q ? sext32(r_c[31:0]) : r_c;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
            op_q   <= '0;
            w_q    <= 1'b0;
            fast_q <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            rd_q   <= '0;
            hi     <= '0;
            lo     <= '0;
            opa    <= '0;
            opb    <= '0;
        end else if (kill) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q   <= op;
                        w_q    <= op_w;
                        rd_q   <= rd_in;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        fast_q <= div_zero | div_ovf;
                        state  <= BUSY;
                        busy   <= 1'b1;
                        opa    <= a_mag;
                        opb    <= b_mag;
                        hi     <= '0;
                        // Fast results are parked in lo and spend a
                        // single counted cycle before DONE.
                        if (div_zero | div_ovf) begin
                            cnt <= 7'd1;
                            lo  <= fast_val;
                        end else begin
                            cnt <= op_w ? 7'd32 : 7'd64;
                            if (!is_div) begin
                                lo <= '0;
                            end else if (op_w) begin
                                lo <= {a_mag[31:0], 32'd0};
                            end else begin
                                lo <= a_mag;
                            end
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 7'd1;
                    if (!fast_q) begin
                        hi  <= hi_n;
                        lo  <= lo_n;
                        opb <= opb_n;
                    end
                    if (cnt == 7'd1) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= res_n;
                        rd_out <= rd_q;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Drives hand-computed vectors and checks result, latency and handshake.

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic        op_w;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [4:0]  rd_in;
    logic        kill;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(64)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .op_w(op_w),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .rd_in(rd_in),
        .kill(kill),
        .busy(busy),
        .done(done),
        .result(result),
        .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Count done pulses over a window where none may appear.
    task automatic quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        chk(tag, seen, 0);
    endtask

    task automatic run(input string tag, input logic [2:0] f3,
                       input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd,
                       input logic [63:0] exp_res, input int exp_lat);
        int n;
        op = f3;
        op_w = w;
        rs1_data = a;
        rs2_data = b;
        rd_in = rd;
        start = 1'b1;
        tick();
        start = 1'b0;
        op = ~f3;
        op_w = ~w;
        rs1_data = {$urandom, $urandom};
        rs2_data = {$urandom, $urandom};
        rd_in = ~rd;
        chk({tag, "_busy"}, busy, 1);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_busy_done"}, busy, 1);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_rd"}, rd_out, rd);
        tick();
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_hold"}, result, exp_res);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        kill = 1'b0;
        op = 3'd0;
        op_w = 1'b0;
        rs1_data = '0;
        rs2_data = '0;
        rd_in = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_rd", rd_out, 0);
        rst = 1'b0;
        tick();

        run("mul", 3'd0, 0, 64'd7, 64'd6, 5'd5, 64'd42, 64);
        run("mulh", 3'd1, 0, '1, '1, 5'd6, 64'd0, 64);
        run("mulhu", 3'd3, 0, '1, '1, 5'd7,
            64'hFFFF_FFFF_FFFF_FFFE, 64);
        run("mulhsu", 3'd2, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd8,
            64'hFFFF_FFFF_FFFF_FFFF, 64);
        run("mul_neg", 3'd0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd9,
            64'hFFFF_FFFF_FFFF_FFF1, 64);
        run("div", 3'd4, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10,
            64'hFFFF_FFFF_FFFF_FFFD, 64);
        run("rem", 3'd6, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11,
            64'hFFFF_FFFF_FFFF_FFFF, 64);
        run("divu", 3'd5, 0, 64'd100, 64'd7, 5'd12, 64'd14, 64);
        run("remu", 3'd7, 0, 64'd100, 64'd7, 5'd13, 64'd2, 64);
        run("div_m1", 3'd4, 0, 64'd10, '1, 5'd14,
            64'hFFFF_FFFF_FFFF_FFF6, 64);
        run("divuw", 3'd5, 1, 64'h0000_0000_FFFF_FFFE, 64'd2, 5'd15,
            64'h0000_0000_7FFF_FFFF, 32);
        run("divw", 3'd4, 1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd16,
            64'hFFFF_FFFF_FFFF_FFFD, 32);
        run("remw", 3'd6, 1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd17,
            64'hFFFF_FFFF_FFFF_FFFF, 32);
        run("remuw", 3'd7, 1, 64'd17, 64'd5, 5'd18, 64'd2, 32);
        run("mulw", 3'd0, 1, 64'h0000_0000_0001_0000, 64'h8000, 5'd19,
            64'hFFFF_FFFF_8000_0000, 32);
        run("divu_z", 3'd5, 0, 64'd123, 64'd0, 5'd20, '1, 1);
        run("rem_ovf", 3'd6, 0, 64'h8000_0000_0000_0000, '1, 5'd21,
            64'd0, 1);
        run("div_ovf", 3'd4, 0, 64'h8000_0000_0000_0000, '1, 5'd22,
            64'h8000_0000_0000_0000, 1);
        run("remw_z", 3'd6, 1, 64'h0000_0000_8000_0005,
            64'hFFFF_FFFF_0000_0000, 5'd23,
            64'hFFFF_FFFF_8000_0005, 1);
        run("divw_ovf", 3'd4, 1, 64'h0000_0000_8000_0000,
            64'h0000_0000_FFFF_FFFF, 5'd0,
            64'hFFFF_FFFF_8000_0000, 1);

        // Flush in the middle of a divide.
        op = 3'd4;
        op_w = 1'b0;
        rs1_data = 64'd100;
        rs2_data = 64'd7;
        rd_in = 5'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (18) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_busy", busy, 0);
        chk("kill_done", done, 0);
        quiet("kill_quiet", 80);
        run("post_kill", 3'd0, 0, 64'd3, 64'd3, 5'd3, 64'd9, 64);

        // Reset in the middle of a multiply.
        op = 3'd0;
        rs1_data = 64'd5;
        rs2_data = 64'd5;
        rd_in = 5'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_result", result, 0);
        chk("mrst_rd", rd_out, 0);
        quiet("mrst_quiet", 80);

        // Kill with start in IDLE drops the request.
        op = 3'd0;
        rs1_data = 64'd2;
        rs2_data = 64'd2;
        rd_in = 5'd1;
        start = 1'b1;
        kill = 1'b1;
        tick();
        start = 1'b0;
        kill = 1'b0;
        chk("ks_busy", busy, 0);
        quiet("ks_quiet", 80);

        // start held high: each accepted request uses its own operands.
        op = 3'd0;
        op_w = 1'b0;
        rs1_data = 64'd2;
        rs2_data = 64'd3;
        rd_in = 5'd1;
        start = 1'b1;
        tick();
        rs1_data = 64'd4;
        rs2_data = 64'd5;
        rd_in = 5'd2;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("hold1_lat", n, 64);
        chk("hold1_res", result, 64'd6);
        chk("hold1_rd", rd_out, 1);
        tick();
        chk("hold_gap_busy", busy, 0);
        chk("hold_gap_done", done, 0);
        tick();
        chk("hold2_busy", busy, 1);
        rs1_data = 64'd7;
        rs2_data = 64'd8;
        rd_in = 5'd3;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        start = 1'b0;
        chk("hold2_lat", n, 64);
        chk("hold2_res", result, 64'd20);
        chk("hold2_rd", rd_out, 2);
        tick();
        chk("hold2_pulse", done, 0);
        chk("hold2_idle", busy, 0);
        quiet("hold_quiet", 80);
        chk("hold_keep", result, 64'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
